// File: rtl/gpio_seqctrl.sv
// Timed command sequencer: CPU-queued GPIO mask/value words replayed as Wishbone writes with cycle-exact delays.
// Optional watchdog on the master bus is enabled by defining GPIO_SEQ_TIMEOUT_EN.
module gpio_seqctrl #(
  parameter int LGFIFO = 4,
  parameter int DW     = 16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [1:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  output logic        o_gpio_cyc,
  output logic        o_gpio_stb,
  output logic        o_gpio_we,
  output logic [31:0] o_gpio_data,
  input  logic        i_gpio_stall,
  input  logic        i_gpio_ack,
  input  logic        i_gpio_err,
  output logic        o_int
);

  localparam int DEPTH = 1 << LGFIFO;
  localparam int EW    = DW + 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_WRITE,
    S_ACK
  } state_t;

  state_t              state_q, state_d;
  logic                enable_q, enable_d;
  logic                err_q, err_d;
  logic                ovfl_q, ovfl_d;
  logic [DW-1:0]       delay_q, delay_d;
  logic [DW-1:0]       cnt_q, cnt_d;
  logic [31:0]         count_q, count_d;
  logic [31:0]         cmd_q, cmd_d;
  logic [31:0]         last_q, last_d;
  logic [LGFIFO-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LGFIFO-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LGFIFO:0]     fill_q, fill_d;
  logic                ack_q, ack_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                int_q, int_d;

  logic [EW-1:0]       mem [DEPTH];
  logic [EW-1:0]       head;

  logic                bus_wr, ctrl_wr, delay_wr, push, count_wr, flush;
  logic                full, empty, push_ok;
  logic                pop, done, fail, accept, timeout;

  assign bus_wr   = i_wb_cyc && i_wb_stb && i_wb_we;
  assign ctrl_wr  = bus_wr && (i_wb_addr == 2'd0);
  assign delay_wr = bus_wr && (i_wb_addr == 2'd1);
  assign push     = bus_wr && (i_wb_addr == 2'd2);
  assign count_wr = bus_wr && (i_wb_addr == 2'd3);
  assign flush    = ctrl_wr && i_wb_data[1];

  // Fullness is taken from the registered fill, so a same-cycle pop never makes room.
  assign full    = (fill_q == (LGFIFO+1)'(DEPTH));
  assign empty   = (fill_q == '0);
  assign push_ok = push && !full;
  assign head    = mem[rd_ptr_q];

`ifdef GPIO_SEQ_TIMEOUT_EN
  logic [7:0] wd_q, wd_d;

  always_comb begin
    wd_d = 8'd0;
    if (state_q == S_WRITE || state_q == S_ACK) begin
      wd_d = wd_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wd_q <= 8'd0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign timeout = (wd_q == 8'hFF);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= {delay_q, i_wb_data};
    end
  end

  // Sequencer: pop -> optional delay -> strobe -> wait for ack.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    done    = 1'b0;
    fail    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable_q && !empty) begin
          pop   = 1'b1;
          cmd_d = head[31:0];
          cnt_d = head[EW-1:32];
          state_d = (head[EW-1:32] != '0) ? S_WAIT : S_WRITE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - DW'(1);
        if (!enable_q) begin
          state_d = S_IDLE;
        end else if (cnt_q == DW'(1)) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (i_gpio_err) begin
          fail = 1'b1;
        end else if (!i_gpio_stall) begin
          accept = 1'b1;
          if (i_gpio_ack) begin
            done = 1'b1;
          end else begin
            state_d = S_ACK;
          end
        end else if (timeout) begin
          fail = 1'b1;
        end
      end
      S_ACK: begin
        if (i_gpio_err) begin
          fail = 1'b1;
        end else if (i_gpio_ack) begin
          done = 1'b1;
        end else if (timeout) begin
          fail = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (done || fail) begin
      state_d = S_IDLE;
    end
  end

  // Command FIFO bookkeeping; flush discards everything queued this cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + LGFIFO'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + LGFIFO'(1);
    end
    case ({push_ok, pop})
      2'b10:   fill_d = fill_q + (LGFIFO+1)'(1);
      2'b01:   fill_d = fill_q - (LGFIFO+1)'(1);
      default: fill_d = fill_q;
    endcase
    if (flush) begin
      rd_ptr_d = wr_ptr_d;
      fill_d   = '0;
    end
  end

  always_comb begin
    enable_d = enable_q;
    err_d    = err_q;
    ovfl_d   = ovfl_q;
    delay_d  = delay_q;
    count_d  = count_q;
    last_d   = last_q;
    if (ctrl_wr) begin
      enable_d = i_wb_data[0];
      if (i_wb_data[2]) begin
        err_d  = 1'b0;
        ovfl_d = 1'b0;
      end
    end
    if (delay_wr) begin
      delay_d = i_wb_data[DW-1:0];
    end
    if (push && full) begin
      ovfl_d = 1'b1;
    end
    if (accept) begin
      last_d = cmd_q;
    end
    if (done) begin
      count_d = count_q + 32'd1;
    end
    if (count_wr) begin
      count_d = 32'd0;
    end
    // A bus fault overrides any same-cycle CPU write to the control bits.
    if (fail) begin
      err_d    = 1'b1;
      enable_d = 1'b0;
    end
  end

  always_comb begin
    ack_d   = i_wb_stb;
    rdata_d = rdata_q;
    int_d   = fail || (done && (fill_d == '0));
    if (i_wb_stb && !i_wb_we) begin
      case (i_wb_addr)
        2'd0: rdata_d = {8'(fill_q), 18'd0, ovfl_q, err_q, (state_q != S_IDLE),
                         full, empty, enable_q};
        2'd1: rdata_d = 32'(delay_q);
        2'd2: rdata_d = last_q;
        default: rdata_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      enable_q <= 1'b0;
      err_q    <= 1'b0;
      ovfl_q   <= 1'b0;
      delay_q  <= '0;
      cnt_q    <= '0;
      count_q  <= 32'd0;
      cmd_q    <= 32'd0;
      last_q   <= 32'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= 32'd0;
      int_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      err_q    <= err_d;
      ovfl_q   <= ovfl_d;
      delay_q  <= delay_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      cmd_q    <= cmd_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      int_q    <= int_d;
    end
  end

  assign o_wb_stall  = 1'b0;
  assign o_wb_ack    = ack_q;
  assign o_wb_data   = rdata_q;
  assign o_gpio_cyc  = (state_q == S_WRITE) || (state_q == S_ACK);
  assign o_gpio_stb  = (state_q == S_WRITE);
  assign o_gpio_we   = 1'b1;
  assign o_gpio_data = cmd_q;
  assign o_int       = int_q;

endmodule

// File: tb/tb_gpio_seqctrl.sv
// Self-checking bench for gpio_seqctrl: randomized command queues checked against a queue-based timing model.
module tb_gpio_seqctrl;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_wb_cyc, i_wb_stb, i_wb_we;
  logic [1:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_wb_stall, o_wb_ack;
  logic [31:0] o_wb_data;
  logic        o_gpio_cyc, o_gpio_stb, o_gpio_we;
  logic [31:0] o_gpio_data;
  logic        i_gpio_stall, i_gpio_ack, i_gpio_err;
  logic        o_int;

  gpio_seqctrl #(.LGFIFO(4), .DW(16)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
    .o_gpio_cyc(o_gpio_cyc), .o_gpio_stb(o_gpio_stb), .o_gpio_we(o_gpio_we),
    .o_gpio_data(o_gpio_data),
    .i_gpio_stall(i_gpio_stall), .i_gpio_ack(i_gpio_ack), .i_gpio_err(i_gpio_err),
    .o_int(o_int)
  );

  always #5 i_clk = ~i_clk;

  int cycle_n = 0;
  always @(posedge i_clk) cycle_n <= cycle_n + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: queued entries and register state.
  typedef struct {
    logic [15:0] d;
    logic [31:0] w;
  } ent_t;
  ent_t        m_q[$];
  logic        m_enable = 1'b0, m_err = 1'b0, m_ovfl = 1'b0;
  logic [31:0] m_count = 32'd0;

  function automatic logic [31:0] m_status();
    logic [7:0] f;
    logic       fl, em;
    f  = 8'(m_q.size());
    fl = (m_q.size() == 16);
    em = (m_q.size() == 0);
    return {f, 18'd0, m_ovfl, m_err, 1'b0, fl, em, m_enable};
  endfunction

  // GPIO slave: acks one cycle after an unstalled strobe; logs strobe rises and interrupts.
  int          stb_cyc[$];
  logic [31:0] stb_dat[$];
  int          int_cnt = 0;
  bit          no_ack = 1'b0;
  logic        prev_stb = 1'b0;
  logic        acc;

  initial begin
    i_gpio_ack = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_int === 1'b1) int_cnt++;
      if (o_gpio_stb === 1'b1 && !prev_stb) begin
        stb_cyc.push_back(cycle_n);
        stb_dat.push_back(o_gpio_data);
      end
      prev_stb = (o_gpio_stb === 1'b1);
      acc = (o_gpio_stb === 1'b1) && !i_gpio_stall && !no_ack;
      @(posedge i_clk);
      #1 i_gpio_ack = acc;
    end
  end

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d, output int c);
    @(posedge i_clk); #2;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_addr = a; i_wb_data = d;
    c = cycle_n;
    @(posedge i_clk); #2;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    @(posedge i_clk); #2;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = a;
    @(posedge i_clk); #2;
    d = o_wb_data;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
  endtask

  task automatic push_cmd(input logic [15:0] d, input logic [31:0] w);
    int c;
    wb_write(2'd1, 32'(d), c);
    wb_write(2'd2, w, c);
    if (m_q.size() < 16) m_q.push_back('{d: d, w: w});
    else m_ovfl = 1'b1;
  endtask

  task automatic wait_stbs(input int n, input int budget);
    for (int k = 0; k < budget && stb_cyc.size() < n; k++) @(posedge i_clk);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    i_reset_n = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    total_cnt++;
    if ({o_gpio_cyc, o_gpio_stb, o_int, o_wb_ack, o_wb_stall} !== 5'b0 || o_gpio_data !== 32'd0)
      $display("FAIL reset_outputs: got cyc=%b stb=%b int=%b ack=%b data=%h, required all 0",
               o_gpio_cyc, o_gpio_stb, o_int, o_wb_ack, o_gpio_data);
    else pass_cnt++;
    @(posedge i_clk); #2 i_reset_n = 1'b1;
    wb_read(2'd0, r);
    total_cnt++;
    if (r !== m_status()) $display("FAIL reset_status: got %h required %h", r, m_status());
    else pass_cnt++;
    wb_read(2'd3, r);
    total_cnt++;
    if (r !== 32'd0) $display("FAIL reset_count: got %h required 0", r);
    else pass_cnt++;
  endtask

  task automatic test_single();
    int en_c, base, ic0, c;
    logic [31:0] r;
    base = stb_cyc.size();
    ic0  = int_cnt;
    push_cmd(16'd0, 32'h0001_0001);
    wb_write(2'd0, 32'd1, en_c);
    m_enable = 1'b1;
    wait_stbs(base + 1, 50);
    total_cnt++;
    if (stb_cyc.size() < base + 1) $display("FAIL single_stb: no strobe within 50 cycles, required 1");
    else begin
      if (stb_cyc[base] !== en_c + 2 || stb_dat[base] !== 32'h0001_0001)
        $display("FAIL single_stb: got cycle %0d data %h required cycle %0d data 00010001",
                 stb_cyc[base] - en_c, stb_dat[base], 2);
      else pass_cnt++;
      void'(m_q.pop_front());
      m_count++;
    end
    repeat (4) @(posedge i_clk);
    wb_read(2'd3, r);
    total_cnt++;
    if (r !== m_count) $display("FAIL single_count: got %0d required %0d", r, m_count);
    else pass_cnt++;
    total_cnt++;
    if (int_cnt - ic0 !== 1) $display("FAIL single_int: got %0d pulses required 1", int_cnt - ic0);
    else pass_cnt++;
    wb_read(2'd2, r);
    total_cnt++;
    if (r !== 32'h0001_0001) $display("FAIL single_last: got %h required 00010001", r);
    else pass_cnt++;
    wb_write(2'd0, 32'd0, c);
    m_enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n, en_c, base, ic0, c, t_exp, tot_delay;
    logic [31:0] r;
    ent_t e;
    n = $urandom_range(4, 7);
    base = stb_cyc.size();
    ic0 = int_cnt;
    tot_delay = 0;
    for (int i = 0; i < n; i++) begin
      logic [15:0] d;
      d = (i == 0) ? 16'd0 : (i == 1) ? 16'd10 : 16'($urandom_range(0, 12));
      tot_delay += int'(d);
      push_cmd(d, $urandom);
    end
    wb_write(2'd0, 32'd1, en_c);
    m_enable = 1'b1;
    wait_stbs(base + n, 4 * n + tot_delay + 40);
    total_cnt++;
    if (stb_cyc.size() < base + n)
      $display("FAIL b2b_strobes: got %0d strobes required %0d", stb_cyc.size() - base, n);
    else pass_cnt++;
    t_exp = en_c + 2;
    for (int i = 0; i < n && base + i < stb_cyc.size(); i++) begin
      e = m_q.pop_front();
      // First entry issues 2 cycles after ENABLE is written; each later one 3 + delay after the previous.
      t_exp = t_exp + ((i == 0) ? 0 : 3) + int'(e.d);
      total_cnt++;
      if (stb_cyc[base+i] !== t_exp || stb_dat[base+i] !== e.w)
        $display("FAIL b2b_entry%0d: got cycle %0d data %h required cycle %0d data %h",
                 i, stb_cyc[base+i], stb_dat[base+i], t_exp, e.w);
      else pass_cnt++;
      m_count++;
    end
    repeat (4) @(posedge i_clk);
    wb_read(2'd3, r);
    total_cnt++;
    if (r !== m_count) $display("FAIL b2b_count: got %0d required %0d", r, m_count);
    else pass_cnt++;
    total_cnt++;
    if (int_cnt - ic0 !== 1) $display("FAIL b2b_int: got %0d pulses required 1", int_cnt - ic0);
    else pass_cnt++;
    wb_write(2'd0, 32'd0, c);
    m_enable = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    int c;
    for (int i = 0; i < 17; i++) push_cmd(16'($urandom_range(0, 100)), $urandom);
    wb_read(2'd0, r);
    total_cnt++;
    if (r !== m_status()) $display("FAIL ovfl_status: got %h required %h", r, m_status());
    else pass_cnt++;
    wb_write(2'd0, 32'h6, c);
    m_q.delete();
    m_ovfl = 1'b0;
    m_err  = 1'b0;
    wb_read(2'd0, r);
    total_cnt++;
    if (r !== m_status()) $display("FAIL flush_status: got %h required %h", r, m_status());
    else pass_cnt++;
  endtask

  task automatic test_stall_err();
    logic [31:0] r, w;
    int c, base, ic0;
    w = $urandom;
    base = stb_cyc.size();
    @(posedge i_clk); #2 i_gpio_stall = 1'b1;
    push_cmd(16'd0, w);
    ic0 = int_cnt;
    wb_write(2'd0, 32'd1, c);
    m_enable = 1'b1;
    wait_stbs(base + 1, 20);
    void'(m_q.pop_front());
    for (int k = 0; k < 5; k++) begin
      @(posedge i_clk); #2;
      total_cnt++;
      if (o_gpio_stb !== 1'b1 || o_gpio_cyc !== 1'b1 || o_gpio_data !== w)
        $display("FAIL stall_hold%0d: got stb=%b cyc=%b data=%h required stb=1 cyc=1 data=%h",
                 k, o_gpio_stb, o_gpio_cyc, o_gpio_data, w);
      else pass_cnt++;
    end
    i_gpio_err = 1'b1;
    @(posedge i_clk); #2;
    i_gpio_err = 1'b0;
    i_gpio_stall = 1'b0;
    m_err = 1'b1;
    m_enable = 1'b0;
    total_cnt++;
    if (o_gpio_cyc !== 1'b0 || o_gpio_stb !== 1'b0)
      $display("FAIL err_drop: got cyc=%b stb=%b required 0 0", o_gpio_cyc, o_gpio_stb);
    else pass_cnt++;
    repeat (2) @(posedge i_clk);
    total_cnt++;
    if (int_cnt - ic0 !== 1) $display("FAIL err_int: got %0d pulses required 1", int_cnt - ic0);
    else pass_cnt++;
    wb_read(2'd0, r);
    total_cnt++;
    if (r !== m_status()) $display("FAIL err_status: got %h required %h", r, m_status());
    else pass_cnt++;
    wb_read(2'd3, r);
    total_cnt++;
    if (r !== m_count) $display("FAIL err_count: got %0d required %0d", r, m_count);
    else pass_cnt++;
    wb_write(2'd0, 32'h4, c);
    m_err = 1'b0;
  endtask

  task automatic test_disable_wait();
    logic [31:0] r;
    int c, base;
    base = stb_cyc.size();
    push_cmd(16'($urandom_range(20, 40)), $urandom);
    wb_write(2'd0, 32'd1, c);
    repeat ($urandom_range(2, 10)) @(posedge i_clk);
    wb_write(2'd0, 32'd0, c);
    void'(m_q.pop_front());
    m_enable = 1'b0;
    repeat (50) @(posedge i_clk);
    total_cnt++;
    if (stb_cyc.size() !== base)
      $display("FAIL wait_discard: got %0d strobes required 0", stb_cyc.size() - base);
    else pass_cnt++;
    wb_read(2'd0, r);
    total_cnt++;
    if (r !== m_status()) $display("FAIL wait_status: got %h required %h", r, m_status());
    else pass_cnt++;
  endtask

  task automatic test_count_clear();
    logic [31:0] r;
    int c;
    wb_write(2'd3, $urandom, c);
    m_count = 32'd0;
    wb_read(2'd3, r);
    total_cnt++;
    if (r !== m_count) $display("FAIL count_clear: got %h required 0", r);
    else pass_cnt++;
  endtask

`ifdef GPIO_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] r;
    int c, base, s, dur;
    no_ack = 1'b1;
    base = stb_cyc.size();
    push_cmd(16'd0, $urandom);
    wb_write(2'd0, 32'd1, c);
    wait_stbs(base + 1, 20);
    void'(m_q.pop_front());
    s = (stb_cyc.size() > base) ? stb_cyc[base] : cycle_n;
    for (int k = 0; k < 400 && o_gpio_cyc === 1'b1; k++) begin
      @(posedge i_clk); #2;
    end
    dur = cycle_n - s;
    total_cnt++;
    if (o_gpio_cyc !== 1'b0 || dur < 255 || dur > 256)
      $display("FAIL timeout_drop: got cyc=%b after %0d cycles required 0 after 255..256",
               o_gpio_cyc, dur);
    else pass_cnt++;
    m_err = 1'b1;
    m_enable = 1'b0;
    no_ack = 1'b0;
    wb_read(2'd0, r);
    total_cnt++;
    if (r !== m_status()) $display("FAIL timeout_status: got %h required %h", r, m_status());
    else pass_cnt++;
    wb_write(2'd0, 32'h4, c);
    m_err = 1'b0;
  endtask
`endif

  initial begin
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    i_wb_addr = 2'd0; i_wb_data = 32'd0;
    i_gpio_stall = 1'b0; i_gpio_err = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_back_to_back();
    test_overflow();
    test_stall_err();
    test_disable_wait();
    test_count_clear();
`ifdef GPIO_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/gpio_seqctrl.md
Name:
gpio_seqctrl

Overview:
- Timed command sequencer for the 16-in/16-out Wishbone GPIO port.
- A CPU queues GPIO write words, each tagged with a pre-issue delay, through a 4-register Wishbone slave.
- The block replays the queue as Wishbone master writes to the GPIO port at cycle-exact spacing, giving jitter-free output waveforms without CPU timing involvement.
- Command words use the GPIO port's mask/value format: bits 31:16 are the change-enable mask, bits 15:0 the new values.

Parameters:
- LGFIFO, 4: log2 of command FIFO depth (16 entries).
- DW, 16: delay field width in bits.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  reset, asynchronous assert, active-low
- i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  slave bus controls
- i_wb_addr  in  2  slave register select
- i_wb_data  in  32  slave write data
- o_wb_stall  out  1  slave stall; tied 0
- o_wb_ack  out  1  slave ack
- o_wb_data  out  32  slave read data
- o_gpio_cyc, o_gpio_stb  out  1 each  master cycle and strobe to GPIO port
- o_gpio_we  out  1  always 1
- o_gpio_data  out  32  command word being issued
- i_gpio_stall, i_gpio_ack, i_gpio_err  in  1 each  master bus responses
- o_int  out  1  one-cycle interrupt pulse

Behaviour:
- Reset (async, i_reset_n=0): all outputs 0; FIFO empty; ENABLE=0; DELAY=0; COUNT=0; sticky flags 0; FSM=IDLE.
- Slave timing: o_wb_ack asserts one cycle after every i_wb_stb; reads are registered on the same strobe.
- Addr 0 CTRL/STATUS
  - Write: bit0 sets ENABLE; bit1=1 flushes the FIFO (self-clearing); bit2=1 clears ERR and OVFL.
  - Read: {fill[LGFIFO:0] in bits 31:24, 0s, OVFL in bit5, ERR in bit4, busy (FSM!=IDLE) in bit3, full in bit2, empty in bit1, ENABLE in bit0}.
- Addr 1 DELAY: R/W, DW bits, zero-extended on read.
- Addr 2 CMD
  - Write: pushes {DELAY, data}.
  - Push while full: entry dropped and OVFL set. Fullness is sampled before any same-cycle pop.
  - Read: returns the last issued command.
- Addr 3 COUNT: read returns completed-command count (32-bit, wraps 0xFFFFFFFF->0); any write clears it.
- Push and pop in the same cycle: both take effect; fill count unchanged.
- FSM states: IDLE, WAIT, WRITE, ACK.
  - IDLE: if ENABLE and FIFO not empty, pop the entry into cmd/cnt. Go to WAIT if delay>0, otherwise WRITE.
  - WAIT: cnt decrements each cycle; at cnt==1 go to WRITE. Delay d places stb exactly d cycles later than the d=0 case.
  - WRITE: o_gpio_cyc=o_gpio_stb=1, o_gpio_data=cmd.
    - When !i_gpio_stall: drop stb, keep cyc, go to ACK.
    - If ack arrives in the accepting cycle: complete immediately.
  - ACK: on i_gpio_ack, drop cyc, increment COUNT, return to IDLE.
- Latency: with a delay=0 entry waiting, stb asserts on the 2nd clock after ENABLE becomes visible (pop cycle + 1).
- Back-to-back: the minimum spacing between consecutive stbs is 3 cycles (pop, stb, ack, each 1 cycle).
- i_gpio_err during WRITE or ACK: drop cyc/stb, set ERR, clear ENABLE, go to IDLE. COUNT does not increment.
- Clearing ENABLE mid-operation:
  - In WAIT: entry is discarded and the FSM goes to IDLE.
  - In WRITE or ACK: the transaction completes; cyc is never dropped before ack or err. The FSM then holds in IDLE.
- Flush: empties the FIFO the same cycle. An in-flight bus transaction still completes.
- o_int: one-cycle pulse when the FSM returns to IDLE with the FIFO empty after a completed command, or when ERR is set.

Optional Feature:
- GPIO_SEQ_TIMEOUT_EN
  - Defined: an 8-bit watchdog counts cycles in WRITE+ACK. On reaching 255 it drops cyc/stb, sets ERR, clears ENABLE, goes to IDLE, and pulses o_int.
  - Undefined: the block waits indefinitely for ack or err.

Test Plan:
1. Reset, then read addr 0 -> 0x00000002 (empty only); all master outputs 0.
2. DELAY=0, push 0x00010001, ENABLE=1 -> o_gpio_stb at 2nd clock with data 0x00010001; ack -> COUNT=1; o_int pulses once.
3. Push A(delay 0) and B(delay 10) with ack returned immediately -> B's stb rises exactly 10 cycles after the back-to-back position (13 cycles after A's stb).
4. Push 17 entries while disabled -> fill=16, full=1, OVFL=1; write 0x6 to addr 0 -> FIFO empty, OVFL=0.
5. Hold i_gpio_stall=1 for 5 cycles -> stb held with data stable; then assert i_gpio_err -> ERR=1, ENABLE=0, o_int pulse, COUNT unchanged.
6. With GPIO_SEQ_TIMEOUT_EN defined and ack withheld -> cyc drops after 255 cycles, ERR=1.
